// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 16;

    // ID/EX control bundle, packed to PIPE_CTRL_W
    typedef struct packed {
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] rsvd;
    } id_ex_ctrl_t;

    // EX/MEM control bundle, packed to PIPE_CTRL_W
    typedef struct packed {
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic [1:0] wb_sel;
        logic [2:0] mem_size;
        logic [7:0] rsvd;
    } ex_mem_ctrl_t;

    // Number of entries held in a given state
    function automatic logic [1:0] pipe_occupancy(input pipe_state_e st);
        case (st)
            PS_ONE:  pipe_occupancy = 2'd1;
            PS_TWO:  pipe_occupancy = 2'd2;
            default: pipe_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload+control register with load and control-clear
module pipe_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Load takes a new entry; clear only kills control so data never toggles on a bubble
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (load) begin
            data_d = d_data;
            ctrl_d = d_ctrl;
        end else if (clear) begin
            ctrl_d = '0;
        end
    end

    // Slot storage, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign q_data = data_q;
    assign q_ctrl = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with valid/ready, flush and optional skid
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    pipe_state_e       state_q, state_d;
    logic              accept, emit;
    logic              main_load, main_clear, main_from_skid, skid_load;
    logic [DATA_W-1:0] main_src_data, skid_data;
    logic [CTRL_W-1:0] main_src_ctrl, skid_ctrl;

    assign out_valid = (state_q != PS_EMPTY);
    assign emit      = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign occupancy = pipe_occupancy(state_q);

    // Next state and slot control; flush overrides any accept/emit this cycle
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_d    = PS_EMPTY;
            main_clear = 1'b1;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_d   = PS_ONE;
                        main_load = 1'b1;
                    end
                end
                PS_ONE: begin
                    if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_d   = PS_TWO;
                        skid_load = 1'b1;
                    end else if (emit) begin
                        state_d    = PS_EMPTY;
                        main_clear = 1'b1;
                    end
                end
                PS_TWO: begin
                    if (emit) begin
                        state_d        = PS_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    // Stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_src_data = main_from_skid ? skid_data : in_data;
    assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_src_data),
        .d_ctrl (main_src_ctrl),
        .q_data (out_data),
        .q_ctrl (out_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q, in_ready_d;

            assign in_ready_d = (state_d != PS_TWO);

            // Registered ready breaks the out_ready -> in_ready path between stages
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (flush),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .q_data (skid_data),
                .q_ctrl (skid_ctrl)
            );
        end else begin : g_noskid
            logic unused_skid_load;

            assign unused_skid_load = skid_load;
            assign in_ready         = out_ready | ~out_valid;
            assign skid_data        = '0;
            assign skid_ctrl        = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (SKID=1 and SKID=0)
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic        out_ready = 1'b0;

    // index 0: SKID=1 build, index 1: SKID=0 build
    logic        ov  [2];
    logic        ir  [2];
    logic [63:0] od  [2];
    logic [15:0] oc  [2];
    logic [1:0]  occ [2];

    int n_assert = 0;
    int n_fail   = 0;

    // reference FIFO per build
    logic [63:0] m_data [2][2];
    logic [15:0] m_ctrl [2][2];
    int          m_cnt  [2];
    logic [63:0] m_last [2];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_ctrl(oc[0]),
        .occupancy(occ[0])
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .SKID(0)) dut_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_ctrl(oc[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input int k);
        if (k == 0) return (m_cnt[0] < 2);
        return (out_ready || m_cnt[1] == 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_last[k] = '0;
        end
    endtask

    task automatic check_all(input string when);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s k%0d out_valid", when, k), 64'(ov[k]), 64'(m_cnt[k] > 0));
            chk($sformatf("%s k%0d occupancy", when, k), 64'(occ[k]), 64'(m_cnt[k]));
            chk($sformatf("%s k%0d out_ctrl", when, k), 64'(oc[k]),
                (m_cnt[k] > 0) ? 64'(m_ctrl[k][0]) : 64'd0);
            chk($sformatf("%s k%0d out_data", when, k), od[k],
                (m_cnt[k] > 0) ? m_data[k][0] : m_last[k]);
            chk($sformatf("%s k%0d in_ready", when, k), 64'(ir[k]), 64'(exp_ready(k)));
            if (!ov[k]) chk($sformatf("%s k%0d bubble_ctrl", when, k), 64'(oc[k]), 64'd0);
        end
        if (!ir[0]) chk({when, " full_when_not_ready"}, 64'(occ[0]), 64'd2);
    endtask

    // drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
    task automatic cyc(input logic iv, input logic [63:0] d, input logic [15:0] c,
                       input logic ordy, input logic fl, input string when);
        logic acc [2];
        logic emt [2];
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all(when);
        for (int k = 0; k < 2; k++) begin
            acc[k] = iv && exp_ready(k);
            emt[k] = (m_cnt[k] > 0) && ordy;
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fl) begin
                    m_cnt[k] = 0;
                end else begin
                    if (emt[k]) begin
                        m_data[k][0] = m_data[k][1];
                        m_ctrl[k][0] = m_ctrl[k][1];
                        m_cnt[k]--;
                    end
                    if (acc[k]) begin
                        m_data[k][m_cnt[k]] = d;
                        m_ctrl[k][m_cnt[k]] = c;
                        m_cnt[k]++;
                    end
                end
                if (m_cnt[k] > 0) m_last[k] = m_data[k][0];
            end
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // reset state, in_ready high while reset held
        cyc(1'b1, 64'h99, 16'hffff, 1'b1, 1'b0, "reset");
        cyc(1'b0, 64'h0, 16'h0, 1'b0, 1'b1, "reset_flush");
        release_rst();

        // 1: full-throughput stream
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, 64'(i), 16'(i * 3), 1'b1, 1'b0, "stream");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "stream_drain");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "stream_idle");

        // 2: stall fills both entries, C held off then delivered in order
        cyc(1'b1, 64'h11, 16'h0a11, 1'b0, 1'b0, "stall_a");
        cyc(1'b1, 64'h22, 16'h0a22, 1'b0, 1'b0, "stall_b");
        cyc(1'b1, 64'h33, 16'h0a33, 1'b0, 1'b0, "stall_c0");
        cyc(1'b1, 64'h33, 16'h0a33, 1'b0, 1'b0, "stall_c1");
        cyc(1'b1, 64'h33, 16'h0a33, 1'b1, 1'b0, "release_a");
        cyc(1'b1, 64'h33, 16'h0a33, 1'b1, 1'b0, "release_b");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "release_c");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "release_idle");

        // 3: flush with a full stage drops everything including the offered D
        cyc(1'b1, 64'h55, 16'h0b55, 1'b0, 1'b0, "fill_1");
        cyc(1'b1, 64'h66, 16'h0b66, 1'b0, 1'b0, "fill_2");
        cyc(1'b1, 64'h44, 16'h0b44, 1'b0, 1'b1, "flush");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "post_flush");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b1, "flush_empty");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "after_flush_empty");

        // 4: bubble inside an all-ones control stream
        cyc(1'b1, 64'hA1, 16'hffff, 1'b1, 1'b0, "bub_1");
        cyc(1'b1, 64'hA2, 16'hffff, 1'b1, 1'b0, "bub_2");
        cyc(1'b0, 64'hA3, 16'hffff, 1'b1, 1'b0, "bub_gap");
        cyc(1'b1, 64'hA4, 16'hffff, 1'b1, 1'b0, "bub_4");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "bub_hole");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "bub_idle");

        // 5: asynchronous reset between edges with stage full
        cyc(1'b1, 64'hC1, 16'h1c1, 1'b0, 1'b0, "pre_rst_1");
        cyc(1'b1, 64'hC2, 16'h1c2, 1'b0, 1'b0, "pre_rst_2");
        cyc(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, "pre_rst_full");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        cyc(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, "rst_held");
        release_rst();

        // 6: toggling out_ready with constant offer
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 64'h600 + 64'(i), 16'h600 + 16'(i), (i % 2) == 0, 1'b0, "toggle");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "toggle_drain1");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "toggle_drain2");

        // randomized traffic with occasional flush
        for (int i = 0; i < 500; i++) begin
            logic        iv, ordy, fl;
            logic [63:0] d;
            logic [15:0] c;
            iv   = ($urandom % 4) != 0;
            ordy = (i < 250) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            fl   = ($urandom % 20) == 0;
            d    = {$urandom, $urandom};
            c    = 16'($urandom);
            cyc(iv, d, c, ordy, fl, "random");
        end
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "final_drain1");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "final_drain2");
        cyc(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
